// File: rtl/icmp_rx_if.sv
// ICMP payload byte stream from the IP receive layer into icmp_rx.
// The master drives the bytes; the parser is the slave.
interface icmp_rx_if;
  logic [7:0] icmp_data;
  logic       icmp_valid;
  logic       icmp_last;

  modport master (output icmp_data, output icmp_valid, output icmp_last);
  modport slave  (input  icmp_data, input  icmp_valid, input  icmp_last);
endinterface

// File: rtl/icmp_rx.sv
// Receive-side ICMP parser: checks the ones-complement checksum and turns a valid
// Echo Request into a reply trigger or a valid Echo Reply into a notification.
module icmp_rx #(
  parameter int unsigned P_MIN_LEN         = 8,
  parameter logic [7:0]  P_ECHO_REQ_TYPE   = 8'd8,
  parameter logic [7:0]  P_ECHO_REPLY_TYPE = 8'd0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  icmp_rx_if.slave    rx,
  output logic        o_trig_reply,
  output logic [15:0] o_trig_seq,
  output logic [15:0] o_trig_id,
  output logic        o_reply_rcvd,
  output logic [15:0] o_reply_seq,
  output logic        o_err_chk,
  output logic        o_err_len
);

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_FOLD1, S_FOLD2, S_CHECK} state_t;

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [31:0] acc_reg, acc_next;
  logic [7:0]  hi_reg, hi_next;
  logic [7:0]  type_reg, type_next;
  logic [7:0]  code_reg, code_next;
  logic [15:0] id_reg, id_next;
  logic [15:0] seq_reg, seq_next;
  logic        trig_reply_next, reply_rcvd_next, err_chk_next, err_len_next;
  logic [15:0] trig_seq_next, trig_id_next, reply_seq_next;

  logic        accept;
  logic [15:0] base_cnt;
  logic [31:0] base_acc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      acc_reg      <= '0;
      hi_reg       <= '0;
      type_reg     <= '0;
      code_reg     <= '0;
      id_reg       <= '0;
      seq_reg      <= '0;
      o_trig_reply <= 1'b0;
      o_trig_seq   <= '0;
      o_trig_id    <= '0;
      o_reply_rcvd <= 1'b0;
      o_reply_seq  <= '0;
      o_err_chk    <= 1'b0;
      o_err_len    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      acc_reg      <= acc_next;
      hi_reg       <= hi_next;
      type_reg     <= type_next;
      code_reg     <= code_next;
      id_reg       <= id_next;
      seq_reg      <= seq_next;
      o_trig_reply <= trig_reply_next;
      o_trig_seq   <= trig_seq_next;
      o_trig_id    <= trig_id_next;
      o_reply_rcvd <= reply_rcvd_next;
      o_reply_seq  <= reply_seq_next;
      o_err_chk    <= err_chk_next;
      o_err_len    <= err_len_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    hi_next         = hi_reg;
    type_next       = type_reg;
    code_next       = code_reg;
    id_next         = id_reg;
    seq_next        = seq_reg;
    trig_reply_next = 1'b0;
    reply_rcvd_next = 1'b0;
    err_chk_next    = 1'b0;
    err_len_next    = 1'b0;
    trig_seq_next   = o_trig_seq;
    trig_id_next    = o_trig_id;
    reply_seq_next  = o_reply_seq;

    // The first beat of a frame is taken in IDLE, so it starts from cleared state.
    accept   = rx.icmp_valid && (state_reg == S_IDLE || state_reg == S_RECV);
    base_cnt = (state_reg == S_IDLE) ? 16'h0000 : cnt_reg;
    base_acc = (state_reg == S_IDLE) ? 32'h0 : acc_reg;
    cnt_next = base_cnt;
    acc_next = base_acc;

    if (accept) begin
      cnt_next = (base_cnt == 16'hFFFF) ? base_cnt : base_cnt + 16'h0001;
      if (!base_cnt[0]) begin
        hi_next = rx.icmp_data;
        if (rx.icmp_last)
          acc_next = base_acc + {16'h0000, rx.icmp_data, 8'h00};
      end else begin
        acc_next = base_acc + {16'h0000, hi_reg, rx.icmp_data};
      end
      case (base_cnt)
        16'd0:   type_next      = rx.icmp_data;
        16'd1:   code_next      = rx.icmp_data;
        16'd4:   id_next[15:8]  = rx.icmp_data;
        16'd5:   id_next[7:0]   = rx.icmp_data;
        16'd6:   seq_next[15:8] = rx.icmp_data;
        16'd7:   seq_next[7:0]  = rx.icmp_data;
        default: ;
      endcase
      state_next = rx.icmp_last ? S_FOLD1 : S_RECV;
    end

    case (state_reg)
      S_FOLD1, S_FOLD2: begin
        acc_next   = {16'h0000, acc_reg[31:16]} + {16'h0000, acc_reg[15:0]};
        state_next = (state_reg == S_FOLD1) ? S_FOLD2 : S_CHECK;
      end
      S_CHECK: begin
        state_next = S_IDLE;
        if (cnt_reg < 16'(P_MIN_LEN)) begin
          err_len_next = 1'b1;
        end else if (acc_reg[15:0] != 16'hFFFF) begin
          err_chk_next = 1'b1;
        end else if (type_reg == P_ECHO_REQ_TYPE && code_reg == 8'h00) begin
          trig_reply_next = 1'b1;
          trig_seq_next   = seq_reg;
          trig_id_next    = id_reg;
        end else if (type_reg == P_ECHO_REPLY_TYPE && code_reg == 8'h00) begin
          reply_rcvd_next = 1'b1;
          reply_seq_next  = seq_reg;
        end
      end
      default: ;
    endcase
  end

endmodule
